// File: rtl/sensor_event_arbiter_pkg.sv
// Shared definitions for the sensor event path.
// Holds the event code values (bit index of ev_in), the code width and a
// fixed-priority helper that picks the lowest set bit. The screen controller
// imports the same package so both sides agree on what each code means.
package sensor_event_arbiter_pkg;

    localparam int unsigned NUM_EV    = 8;
    localparam int unsigned EV_CODE_W = 3;

    typedef logic [EV_CODE_W-1:0] ev_code_t;

    localparam ev_code_t EV_PRESSED   = 3'd0;
    localparam ev_code_t EV_TOUCHED   = 3'd1;
    localparam ev_code_t EV_AWAKING   = 3'd2;
    localparam ev_code_t EV_EXPECTING = 3'd3;
    localparam ev_code_t EV_UP        = 3'd4;
    localparam ev_code_t EV_DOWN      = 3'd5;
    localparam ev_code_t EV_LEFT      = 3'd6;
    localparam ev_code_t EV_RIGHT     = 3'd7;

    // Index of the lowest set bit; bit 0 (pressed) has the highest priority.
    // Returns 0 for an all-zero vector, so callers must qualify with |vec.
    function automatic ev_code_t lowest_set(input logic [NUM_EV-1:0] vec);
        ev_code_t idx;
        idx = '0;
        for (int i = NUM_EV - 1; i >= 0; i--) begin
            if (vec[i]) idx = EV_CODE_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/event_fifo.sv
// Small synchronous FIFO holding granted event codes.
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-low reset (empties the queue)
//   push       write push_data (ignored when full)
//   push_data  entry to write
//   pop        drop the head entry (ignored when empty)
//   pop_data   head entry, forced to 0 while empty
//   full       occupancy == DEPTH
//   empty      occupancy == 0
//   level      occupancy, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap naturally.
module event_fifo
    import sensor_event_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = EV_CODE_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [LW-1:0]    r_level;

    logic w_do_push;
    logic w_do_pop;

    always_comb begin
        full      = (r_level == LW'(DEPTH));
        empty     = (r_level == '0);
        w_do_push = push & ~full;
        w_do_pop  = pop & ~empty;
        pop_data  = empty ? '0 : r_mem[r_rd_ptr];
        level     = r_level;
    end

    // Storage needs no reset: contents are only visible while non-empty.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= push_data;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/sensor_event_arbiter.sv
// Turns eight sensor level flags into a rate-limited queue of event codes.
// Rising edges set per-source pending bits; at most one pending source is
// granted per HOLDOFF cycles (lowest index wins) and its code is queued.
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-low reset
//   ev_in      sensor level flags, bit index == event code
//   ev_valid   queue head holds an event
//   ev_code    event code at queue head
//   ev_ready   consumer accepts the head this cycle
//   level      queue occupancy
//   coalesced  sticky: an edge hit a source that was already pending
//   clr_flag   single-cycle pulse clearing coalesced
module sensor_event_arbiter
    import sensor_event_arbiter_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned HOLDOFF    = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_EV-1:0]    ev_in,
    output logic                 ev_valid,
    output logic [EV_CODE_W-1:0] ev_code,
    input  logic                 ev_ready,
    output logic [2:0]           level,
    output logic                 coalesced,
    input  logic                 clr_flag
);

    localparam int unsigned HO_W = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
    localparam int unsigned LW   = $clog2(FIFO_DEPTH) + 1;

    logic [NUM_EV-1:0] r_prev;
    logic [NUM_EV-1:0] r_pending;
    logic [HO_W-1:0]   r_holdoff;
    logic              r_coalesced;

    logic [NUM_EV-1:0] w_edge;
    logic [NUM_EV-1:0] w_win_mask;
    logic [NUM_EV-1:0] w_clear_mask;
    logic [NUM_EV-1:0] w_pending_d;
    logic [HO_W-1:0]   w_holdoff_d;
    logic              w_coalesced_d;
    ev_code_t          w_win_code;
    logic              w_grant;
    logic              w_full;
    logic              w_empty;
    logic              w_pop;
    logic [LW-1:0]     w_level;

    always_comb begin
        w_edge     = ev_in & ~r_prev;
        w_win_code = lowest_set(r_pending);
        w_win_mask = NUM_EV'(1) << w_win_code;
        // Fullness is the registered state, so a pop this cycle never frees a slot
        // for a push in the same cycle.
        w_grant    = (r_holdoff == '0) && !w_full && (r_pending != '0);

        w_clear_mask = w_grant ? w_win_mask : '0;
        // A fresh edge on the winner re-arms it: the OR comes after the clear.
        w_pending_d  = (r_pending & ~w_clear_mask) | w_edge;

        // An edge on the bit being granted this cycle is a new event, not a merge.
        w_coalesced_d = r_coalesced;
        if (clr_flag) w_coalesced_d = 1'b0;
        if (|(w_edge & r_pending & ~w_clear_mask)) w_coalesced_d = 1'b1;

        w_holdoff_d = r_holdoff;
        if (w_grant) begin
            w_holdoff_d = HO_W'(HOLDOFF - 1);
        end else if (r_holdoff != '0) begin
            w_holdoff_d = r_holdoff - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            // Track ev_in during reset so levels already high at release are not edges.
            r_prev      <= ev_in;
            r_pending   <= '0;
            r_holdoff   <= '0;
            r_coalesced <= 1'b0;
        end else begin
            r_prev      <= ev_in;
            r_pending   <= w_pending_d;
            r_holdoff   <= w_holdoff_d;
            r_coalesced <= w_coalesced_d;
        end
    end

    assign ev_valid  = ~w_empty;
    assign w_pop     = ev_valid & ev_ready;
    assign level     = 3'(w_level);
    assign coalesced = r_coalesced;

    event_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (EV_CODE_W)
    ) u_event_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (w_grant),
        .push_data (w_win_code),
        .pop       (w_pop),
        .pop_data  (ev_code),
        .full      (w_full),
        .empty     (w_empty),
        .level     (w_level)
    );

endmodule

// File: tb/tb_sensor_event_arbiter.sv
// Directed bench for sensor_event_arbiter (FIFO_DEPTH=4, HOLDOFF=16).
// Expected event codes go into a queue as stimulus is issued; a negedge
// monitor pops and compares each accepted event.
module tb_sensor_event_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] ev_in;
    logic       ev_valid;
    logic [2:0] ev_code;
    logic       ev_ready;
    logic [2:0] level;
    logic       coalesced;
    logic       clr_flag;

    int         checks = 0;
    int         errors = 0;
    logic [2:0] exp_q[$];

    always #5 clk = ~clk;

    sensor_event_arbiter #(
        .FIFO_DEPTH (4),
        .HOLDOFF    (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ev_in     (ev_in),
        .ev_valid  (ev_valid),
        .ev_code   (ev_code),
        .ev_ready  (ev_ready),
        .level     (level),
        .coalesced (coalesced),
        .clr_flag  (clr_flag)
    );

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, req, $time);
        end
    endtask

    // Advance n rising edges, then settle 1 time unit past the edge.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One-cycle high pulse on a single ev_in bit.
    task automatic pulse_bit(input int b);
        ev_in = 8'h01 << b;
        tick(1);
        ev_in = 8'h00;
    endtask

    // Scoreboard monitor: every accepted head must match the oldest expectation.
    always @(negedge clk) begin
        if (rst === 1'b1 && ev_valid === 1'b1 && ev_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_event: got code %0d want none at %0t", ev_code, $time);
            end else begin
                check("event_code", 8'(ev_code), 8'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        rst      = 1'b0;
        ev_in    = 8'h00;
        ev_ready = 1'b0;
        clr_flag = 1'b0;
        tick(3);
        check("reset_valid", 8'(ev_valid), 8'd0);
        check("reset_level", 8'(level), 8'd0);
        check("reset_code", 8'(ev_code), 8'd0);
        check("reset_coalesced", 8'(coalesced), 8'd0);
        rst = 1'b1;
        tick(2);

        // Single edge on bit 1: valid appears after the second edge, for one cycle.
        ev_ready = 1'b1;
        ev_in    = 8'h02;
        exp_q.push_back(3'd1);
        tick(1);
        check("single_no_early_valid", 8'(ev_valid), 8'd0);
        tick(1);
        check("single_valid", 8'(ev_valid), 8'd1);
        check("single_code", 8'(ev_code), 8'd1);
        check("single_level", 8'(level), 8'd1);
        tick(1);
        check("single_drained", 8'(level), 8'd0);
        ev_in = 8'h00;
        tick(20);

        // Simultaneous edges on bits 0 and 7: 7 follows 0 by exactly HOLDOFF cycles.
        ev_in = 8'h81;
        exp_q.push_back(3'd0);
        exp_q.push_back(3'd7);
        tick(2);
        check("simul_first_valid", 8'(ev_valid), 8'd1);
        check("simul_first_code", 8'(ev_code), 8'd0);
        tick(15);
        check("simul_holdoff_gap", 8'(ev_valid), 8'd0);
        tick(1);
        check("simul_second_valid", 8'(ev_valid), 8'd1);
        check("simul_second_code", 8'(ev_code), 8'd7);
        ev_in = 8'h00;
        tick(20);

        // Backpressure: six sources, queue holds four, last two wait in pending.
        ev_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back(3'(i));
            pulse_bit(i);
            tick(17);
        end
        check("bp_level_full", 8'(level), 8'd4);
        check("bp_head_code", 8'(ev_code), 8'd0);
        ev_ready = 1'b1;
        tick(40);
        check("bp_level_drained", 8'(level), 8'd0);
        check("bp_no_loss", 8'(exp_q.size()), 8'd0);

        // Coalescing: two edges on bit 2 while holdoff from a bit-0 grant is active.
        exp_q.push_back(3'd0);
        ev_in = 8'h01;
        tick(2);
        ev_in = 8'h00;
        tick(1);
        exp_q.push_back(3'd2);
        pulse_bit(2);
        tick(1);
        pulse_bit(2);
        tick(1);
        check("coalesce_set", 8'(coalesced), 8'd1);
        tick(25);
        check("coalesce_sticky", 8'(coalesced), 8'd1);
        check("coalesce_one_event", 8'(exp_q.size()), 8'd0);
        clr_flag = 1'b1;
        tick(1);
        clr_flag = 1'b0;
        check("coalesce_cleared", 8'(coalesced), 8'd0);
        tick(5);

        // Reset mid-operation with three queued and one pending; ev_in high across release.
        ev_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            pulse_bit(i);
            tick(17);
        end
        pulse_bit(3);
        check("rst_pre_level", 8'(level), 8'd3);
        rst   = 1'b0;
        ev_in = 8'hFF;
        tick(1);
        check("rst_valid_low", 8'(ev_valid), 8'd0);
        check("rst_level_zero", 8'(level), 8'd0);
        tick(2);
        rst = 1'b1;
        tick(30);
        check("rst_no_events_level", 8'(level), 8'd0);
        check("rst_no_events_valid", 8'(ev_valid), 8'd0);
        ev_in = 8'h00;
        tick(2);

        // Full queue plus pop: the pop cycle must not push the pending bit 6.
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(3'(i));
            pulse_bit(i);
            tick(17);
        end
        exp_q.push_back(3'd6);
        pulse_bit(6);
        tick(1);
        check("full_level", 8'(level), 8'd4);
        ev_ready = 1'b1;
        tick(1);
        ev_ready = 1'b0;
        check("full_pop_no_push", 8'(level), 8'd3);
        tick(1);
        check("full_push_next", 8'(level), 8'd4);
        ev_ready = 1'b1;
        tick(30);
        check("full_drained", 8'(level), 8'd0);
        check("queue_drained", 8'(exp_q.size()), 8'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
